// File: rtl/fractal_sync_nbr_initiator.sv
// Neighbor-protocol initiator: turns one sync/lock/free command into a request pulse.
// Tracks the response to completion. Optional wait timeout: FSYNC_NBR_INIT_TIMEOUT_EN.
package fractal_sync_nbr_pkg;
  localparam int unsigned NBR_ID_W = 2;

  typedef struct packed {
    logic [NBR_ID_W-1:0] id;
  } fsync_nbr_req_sig_t;

  typedef struct packed {
    logic               sync;
    logic               lock;
    logic               free;
    fsync_nbr_req_sig_t sig;
  } fsync_nbr_req_t;

  typedef struct packed {
    logic                aggr;
    logic [NBR_ID_W-1:0] id;
  } fsync_nbr_rsp_sig_t;

  typedef struct packed {
    logic               wake;
    logic               grant;
    logic               error;
    fsync_nbr_rsp_sig_t sig;
  } fsync_nbr_rsp_t;
endpackage

module fractal_sync_nbr_initiator #(
  parameter type fsync_req_t = fractal_sync_nbr_pkg::fsync_nbr_req_t,
  parameter type fsync_rsp_t = fractal_sync_nbr_pkg::fsync_nbr_rsp_t,
  parameter int unsigned ID_W = 2,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            cmd_valid_i,
  output logic            cmd_ready_o,
  input  logic [1:0]      cmd_op_i,
  input  logic [ID_W-1:0] cmd_id_i,
  output fsync_req_t      req_o,
  input  fsync_rsp_t      rsp_i,
  output logic            busy_o,
  output logic            grant_o,
  output logic            done_o,
  output logic            done_err_o,
  output logic            done_timeout_o,
  output logic [ID_W-1:0] done_id_o
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  logic [1:0]      state_q;
  logic [1:0]      op_q;
  logic [ID_W-1:0] id_q;
  fsync_req_t      req_q;
  logic            grant_q;
  logic            err_q;
  logic            to_q;
  logic            wake;
  logic            rsp_err;
  logic            tmo;
  logic            posted;
  logic            unused_ok;

  assign wake    = rsp_i.wake;
  assign rsp_err = rsp_i.error | (rsp_i.sig.id != id_q);
  assign posted  = (state_q == ISSUE) && (op_q != 2'd0);

`ifdef FSYNC_NBR_INIT_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES);

  logic [CNT_W-1:0] cnt_q;

  assign tmo = (state_q == WAIT) &&
               (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else if (state_q == IDLE && cmd_valid_i) begin
      cnt_q <= '0;
    end else if (state_q == WAIT) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign unused_ok = ^rsp_i.sig.aggr;
`else
  assign tmo       = 1'b0;
  assign unused_ok = ^rsp_i.sig.aggr ^ (TIMEOUT_CYCLES == 0);
`endif

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      op_q    <= '0;
      id_q    <= '0;
      req_q   <= '0;
      grant_q <= 1'b0;
      err_q   <= 1'b0;
      to_q    <= 1'b0;
    end else begin
      req_q <= '0;
      unique case (state_q)
        IDLE: begin
          if (cmd_valid_i) begin
            op_q  <= cmd_op_i;
            id_q  <= cmd_id_i;
            to_q  <= 1'b0;
            err_q <= (cmd_op_i == 2'd3);
            if (cmd_op_i == 2'd3) begin
              state_q <= DONE;
            end else begin
              state_q         <= ISSUE;
              req_q.sync      <= (cmd_op_i == 2'd0);
              req_q.lock      <= (cmd_op_i == 2'd1);
              req_q.free      <= (cmd_op_i == 2'd2);
              req_q.sig.id    <= cmd_id_i;
            end
          end
        end
        ISSUE, WAIT: begin
          // Wake beats a simultaneous grant or timeout
          if (posted) begin
            state_q <= DONE;
            grant_q <= 1'b0;
          end else if (wake) begin
            state_q <= DONE;
            err_q   <= rsp_err;
            grant_q <= 1'b0;
          end else if (tmo) begin
            state_q <= DONE;
            err_q   <= 1'b1;
            to_q    <= 1'b1;
            grant_q <= 1'b0;
          end else begin
            state_q <= WAIT;
            if (rsp_i.grant) grant_q <= 1'b1;
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign cmd_ready_o    = (state_q == IDLE);
  assign busy_o         = (state_q != IDLE);
  assign req_o          = req_q;
  assign grant_o        = grant_q;
  assign done_o         = (state_q == DONE);
  assign done_err_o     = err_q;
  assign done_timeout_o = to_q;
  assign done_id_o      = id_q;

endmodule

// File: tb/tb_fractal_sync_nbr_initiator.sv
// Scoreboard bench for fractal_sync_nbr_initiator.
// Timeout scenarios run when FSYNC_NBR_INIT_TIMEOUT_EN is defined.
module tb_fractal_sync_nbr_initiator;
  typedef fractal_sync_nbr_pkg::fsync_nbr_req_t req_t;
  typedef fractal_sync_nbr_pkg::fsync_nbr_rsp_t rsp_t;

  typedef struct {
    logic       err;
    logic       to;
    logic [1:0] id;
    int         cyc;
  } dexp_t;

  typedef struct {
    logic [1:0] op;
    logic [1:0] id;
    int         cyc;
  } rexp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [1:0] cmd_op = '0;
  logic [1:0] cmd_id = '0;
  req_t       req;
  rsp_t       rsp;
  logic       busy, grant, done, done_err, done_to;
  logic [1:0] done_id;

  int cyc = 0;
  int checks = 0;
  int errors = 0;
  dexp_t dq[$];
  rexp_t rq[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  fractal_sync_nbr_initiator #(
    .ID_W(2),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clk_i(clk),
    .rst_ni(rst_n),
    .cmd_valid_i(cmd_valid),
    .cmd_ready_o(cmd_ready),
    .cmd_op_i(cmd_op),
    .cmd_id_i(cmd_id),
    .req_o(req),
    .rsp_i(rsp),
    .busy_o(busy),
    .grant_o(grant),
    .done_o(done),
    .done_err_o(done_err),
    .done_timeout_o(done_to),
    .done_id_o(done_id)
  );

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic idle_rsp();
    rsp = '0;
    rsp.error = 1'b1;
  endtask

  // Monitor: compares DUT outputs against the scoreboard queues
  always @(negedge clk) begin
    if (rst_n) begin
      if (done) begin
        if (dq.size() == 0) begin
          chk("done_unexpected", 32'(done), 32'd0);
        end else begin
          dexp_t e;
          e = dq.pop_front();
          chk("done_cycle", 32'(cyc), 32'(e.cyc));
          chk("done_err", 32'(done_err), 32'(e.err));
          chk("done_timeout", 32'(done_to), 32'(e.to));
          chk("done_id", 32'(done_id), 32'(e.id));
        end
      end
      if (req != '0) begin
        if (rq.size() == 0) begin
          chk("req_unexpected", 32'(req), 32'd0);
        end else begin
          rexp_t r;
          req_t  x;
          r = rq.pop_front();
          x = '0;
          x.sync = (r.op == 2'd0);
          x.lock = (r.op == 2'd1);
          x.free = (r.op == 2'd2);
          x.sig.id = r.id;
          chk("req_cycle", 32'(cyc), 32'(r.cyc));
          chk("req_value", 32'(req), 32'(x));
        end
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    while (!cmd_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) chk("idle_timeout", 32'(cmd_ready), 32'd1);
  endtask

  // d: cycle (1 = ISSUE) carrying wake; tmo: never wake
  task automatic run_cmd(input logic [1:0] op,
                         input logic [1:0] id,
                         input int d,
                         input bit gr,
                         input logic [1:0] rid,
                         input bit rerr,
                         input bit tmo);
    logic gseen = 1'b0;
    int   last;
    last = tmo ? 9 : d;
    if (op != 2'd3) rq.push_back('{op, id, cyc + 1});
    if (op == 2'd3)
      dq.push_back('{1'b1, 1'b0, id, cyc + 1});
    else if (op != 2'd0)
      dq.push_back('{1'b0, 1'b0, id, cyc + 2});
    else if (tmo)
      dq.push_back('{1'b1, 1'b1, id, cyc + last + 1});
    else
      dq.push_back('{rerr | (rid != id), 1'b0, id, cyc + d + 1});
    cmd_valid = 1'b1;
    cmd_op = op;
    cmd_id = id;
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_op = 2'($urandom);
    cmd_id = 2'($urandom);
    chk("busy_inflight", 32'(busy), 32'd1);
    chk("ready_inflight", 32'(cmd_ready), 32'd0);
    if (op == 2'd0) begin
      for (int c = 1; c <= last; c++) begin
        if (c >= 2) chk("grant_wait", 32'(grant), 32'(gseen));
        rsp = '0;
        rsp.wake = (c == last) && !tmo;
        rsp.grant = gr && (c < last || $urandom_range(0, 1) == 1);
        rsp.error = rsp.wake ? rerr : 1'($urandom);
        rsp.sig.id = rsp.wake ? rid : 2'($urandom);
        rsp.sig.aggr = 1'($urandom);
        if (!rsp.wake) gseen = gseen | rsp.grant;
        @(negedge clk);
      end
      chk("grant_done", 32'(grant), 32'd0);
    end else if (op != 2'd3) begin
      rsp = rsp_t'($urandom);
      @(negedge clk);
    end
    idle_rsp();
    wait_idle();
  endtask

  task automatic reset_in_wait();
    rq.push_back('{2'd0, 2'd1, cyc + 1});
    cmd_valid = 1'b1;
    cmd_op = 2'd0;
    cmd_id = 2'd1;
    @(negedge clk);
    cmd_valid = 1'b0;
    rsp.grant = 1'b1;
    @(negedge clk);
    idle_rsp();
    @(negedge clk);
    chk("grant_pre_rst", 32'(grant), 32'd1);
    chk("busy_pre_rst", 32'(busy), 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst_ready", 32'(cmd_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_req", 32'(req), 32'd0);
    chk("rst_status", {29'd0, done_err, done_to, 1'b0}, 32'd0);
    chk("rst_done_id", 32'(done_id), 32'd0);
    rst_n = 1'b1;
    rsp = '0;
    rsp.wake = 1'b1;
    rsp.sig.id = 2'd1;
    @(negedge clk);
    idle_rsp();
    chk("late_wake_done", 32'(done), 32'd0);
    chk("late_wake_ready", 32'(cmd_ready), 32'd1);
    @(negedge clk);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    idle_rsp();
    repeat (3) @(negedge clk);
    chk("reset_ready", 32'(cmd_ready), 32'd1);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_grant", 32'(grant), 32'd0);
    chk("reset_req", 32'(req), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    run_cmd(2'd1, 2'd2, 1, 0, 2'd2, 0, 0);
    run_cmd(2'd0, 2'd1, 5, 1, 2'd1, 0, 0);
    run_cmd(2'd0, 2'd1, 2, 0, 2'd3, 0, 0);
    run_cmd(2'd0, 2'd2, 3, 0, 2'd2, 1, 0);
    run_cmd(2'd3, 2'd3, 1, 0, 2'd3, 0, 0);
    run_cmd(2'd0, 2'd0, 1, 1, 2'd0, 0, 0);
    run_cmd(2'd2, 2'd1, 1, 0, 2'd1, 0, 0);
    reset_in_wait();
`ifdef FSYNC_NBR_INIT_TIMEOUT_EN
    run_cmd(2'd0, 2'd2, 9, 1, 2'd2, 0, 1);
    run_cmd(2'd0, 2'd3, 9, 0, 2'd3, 0, 0);
`else
    run_cmd(2'd0, 2'd1, 20, 1, 2'd1, 0, 0);
`endif

    for (int i = 0; i < 60; i++) begin
      logic [1:0] op, id, rid;
      op = 2'($urandom_range(0, 3));
      id = 2'($urandom);
      rid = ($urandom_range(0, 3) == 0) ? 2'($urandom) : id;
      run_cmd(op, id, $urandom_range(1, 6),
              1'($urandom), rid,
              $urandom_range(0, 3) == 0, 0);
    end

    repeat (3) @(negedge clk);
    chk("done_queue_empty", 32'(dq.size()), 32'd0);
    chk("req_queue_empty", 32'(rq.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end
endmodule
